// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait and retired counter.
// Optional feature macro CU_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP (illegal_op=1) until reset.
module multicycle_control_unit #(
    parameter int INSTR_W = 20,
    parameter int OPC_W   = 4,
    parameter int OPC_LSB = 16,
    parameter int IMM_BIT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               mem_ready,
    input  logic               branch_taken,
    output logic               immediate,
    output logic               pcWrite,
    output logic               regWrite,
    output logic               load,
    output logic               memoryRead,
    output logic               memoryWrite,
    output logic               branch,
    output logic               ALUControl,
    output logic               pcMux,
    output logic               store,
    output logic               busy,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
`ifdef CU_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t             state, state_n;
    logic [INSTR_W-1:0] ir;
    logic [OPC_W-1:0]   opc;
    logic               is_alu, is_jump, is_load, is_store, is_branch;

    assign opc       = ir[OPC_LSB +: OPC_W];
    assign is_alu    = (opc >= OPC_W'(1)) && (opc <= OPC_W'(4));
    assign is_jump   = opc == OPC_W'(5);
    assign is_load   = opc == OPC_W'(6);
    assign is_store  = opc == OPC_W'(7);
    assign is_branch = opc == OPC_W'(8);
    assign busy      = state != FETCH;
`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = state == TRAP;
`endif

    // State register, instruction latch and retired counter (one count per pcWrite)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_n;
            if (instr_valid && instr_ready) ir <= instr;
            if (pcWrite) retired <= retired + 1'b1;
        end
    end

    // Next-state and datapath strobes from (state, ir); pcMux/pcWrite also see branch_taken/mem_ready
    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        immediate   = 1'b0;
        pcWrite     = 1'b0;
        regWrite    = 1'b0;
        load        = 1'b0;
        memoryRead  = 1'b0;
        memoryWrite = 1'b0;
        branch      = 1'b0;
        ALUControl  = 1'b0;
        pcMux       = 1'b0;
        store       = 1'b0;
        case (state)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) state_n = DECODE;
            end
            DECODE: state_n = EXEC;
            EXEC: begin
                if (is_alu) begin
                    ALUControl = 1'b1;
                    immediate  = ir[IMM_BIT];
                    state_n    = WB;
                end else if (is_jump) begin
                    pcMux   = 1'b1;
                    pcWrite = 1'b1;
                    state_n = FETCH;
                end else if (is_branch) begin
                    branch  = 1'b1;
                    pcWrite = 1'b1;
                    pcMux   = branch_taken;
                    state_n = FETCH;
                end else if (is_load || is_store) begin
                    state_n = MEM;
`ifdef CU_ILLEGAL_TRAP_EN
                end else if (opc >= OPC_W'(9)) begin
                    state_n = TRAP;
`endif
                end else begin
                    pcWrite = 1'b1;
                    state_n = FETCH;
                end
            end
            MEM: begin
                if (is_load) begin
                    memoryRead = 1'b1;
                    load       = 1'b1;
                    if (mem_ready) state_n = WB;
                end else begin
                    memoryWrite = 1'b1;
                    store       = 1'b1;
                    pcWrite     = mem_ready;
                    if (mem_ready) state_n = FETCH;
                end
            end
            WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                load     = is_load;
                state_n  = FETCH;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            TRAP: state_n = TRAP;
`endif
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard-driven directed bench for the multi-cycle control FSM.
module tb_multicycle_control_unit;
    localparam logic [11:0] B_BUSY = 12'h800, B_RDY = 12'h400, B_IMM = 12'h200, B_PCW = 12'h100,
                            B_RW = 12'h080, B_LD = 12'h040, B_MR = 12'h020, B_MW = 12'h010,
                            B_BR = 12'h008, B_ALU = 12'h004, B_PCM = 12'h002, B_ST = 12'h001;

    typedef struct {
        logic        mr;
        logic        bt;
        logic [11:0] e;
        string       tag;
    } step_t;

    logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
    logic [19:0] instr = '0;
    logic        instr_ready, immediate, pcWrite, regWrite, load, memoryRead, memoryWrite;
    logic        branch, ALUControl, pcMux, store, busy;
    logic [1:0]  retired;
    logic [11:0] obs;
    logic [1:0]  exp_ret = '0;
    int          passed = 0, total = 0;
    step_t       q[$];
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    multicycle_control_unit #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .immediate(immediate), .pcWrite(pcWrite),
        .regWrite(regWrite), .load(load), .memoryRead(memoryRead), .memoryWrite(memoryWrite),
        .branch(branch), .ALUControl(ALUControl), .pcMux(pcMux), .store(store), .busy(busy),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .retired(retired)
    );

    assign obs = {busy, instr_ready, immediate, pcWrite, regWrite, load, memoryRead, memoryWrite,
                  branch, ALUControl, pcMux, store};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input logic mr, input logic bt, input logic [11:0] e, input string tag);
        q.push_back('{mr, bt, e, tag});
    endtask

    // One instruction: fill scoreboard with per-cycle expectations, accept it, then pop/compare each cycle
    task automatic run(input logic [3:0] opc, input logic imm, input int n, input logic bt, input string tag);
        push(1'b1, ~bt, B_BUSY, {tag, "_dec"});
        if (opc >= 4'd1 && opc <= 4'd4) begin
            push(1'b1, ~bt, B_BUSY | B_ALU | (imm ? B_IMM : 12'h0), {tag, "_exec"});
            push(1'b0, ~bt, B_BUSY | B_RW | B_PCW, {tag, "_wb"});
        end else if (opc == 4'd5) begin
            push(1'b1, bt, B_BUSY | B_PCM | B_PCW, {tag, "_exec"});
        end else if (opc == 4'd8) begin
            push(1'b1, bt, B_BUSY | B_BR | B_PCW | (bt ? B_PCM : 12'h0), {tag, "_exec"});
        end else if (opc == 4'd6) begin
            push(1'b1, bt, B_BUSY, {tag, "_exec"});
            for (int i = 0; i < n; i++) push(i == n - 1, bt, B_BUSY | B_MR | B_LD, {tag, "_mem"});
            push(1'b0, bt, B_BUSY | B_RW | B_PCW | B_LD, {tag, "_wb"});
        end else if (opc == 4'd7) begin
            push(1'b1, bt, B_BUSY, {tag, "_exec"});
            for (int i = 0; i < n; i++)
                push(i == n - 1, bt, B_BUSY | B_MW | B_ST | (i == n - 1 ? B_PCW : 12'h0), {tag, "_mem"});
        end else begin
            push(1'b1, bt, B_BUSY | B_PCW, {tag, "_exec"});
        end
        @(negedge clk);
        instr = {opc, imm, 15'($urandom)};
        instr_valid = 1'b1;
        mem_ready = 1'b1;
        #1 chk({tag, "_fetch"}, obs, B_RDY);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ready = s.mr;
            branch_taken = s.bt;
            #1 chk(s.tag, obs, s.e);
        end
        exp_ret = exp_ret + 2'd1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk({tag, "_done"}, obs, B_RDY);
        chk({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        exp_ret = '0;
        #1 chk({tag, "_rst_obs"}, obs, B_RDY);
        chk({tag, "_rst_retired"}, retired, exp_ret);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 chk("reset_obs", obs, B_RDY);
        chk("reset_retired", retired, 2'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk("idle_fetch", obs, B_RDY);
        end
        run(4'd1, 1'b1, 0, 1'b0, "alu_imm");
        run(4'd3, 1'b0, 0, 1'b1, "alu_reg");
        run(4'd6, 1'b0, 4, 1'b0, "load_wait");
        run(4'd7, 1'b0, 1, 1'b0, "store_fast");
        run(4'd7, 1'b0, 3, 1'b1, "store_wait");
        run(4'd8, 1'b0, 0, 1'b1, "branch_taken");
        run(4'd8, 1'b0, 0, 1'b0, "branch_not");
        run(4'd5, 1'b0, 0, 1'b0, "jump");
        run(4'd0, 1'b0, 0, 1'b1, "nop");
        // Reset in the middle of a LOAD memory wait
        @(negedge clk);
        instr = {4'd6, 16'h0};
        instr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ready = 1'b0;
        end
        #1 chk("rst_load_mem", obs, B_BUSY | B_MR | B_LD);
        do_reset("mid_load");
`ifdef CU_ILLEGAL_TRAP_EN
        @(negedge clk);
        instr = {4'hF, 16'h0};
        instr_valid = 1'b1;
        @(negedge clk);
        #1 chk("illegal_dec", obs, B_BUSY);
        @(negedge clk);
        #1 chk("illegal_exec", obs, B_BUSY);
        repeat (3) begin
            @(negedge clk);
            #1 chk("trap_obs", obs, B_BUSY);
            chk("trap_flag", illegal_op, 1'b1);
            chk("trap_retired", retired, exp_ret);
        end
        do_reset("trap");
        chk("trap_cleared", illegal_op, 1'b0);
`else
        run(4'hF, 1'b1, 0, 1'b0, "illegal_nop");
        run(4'h9, 1'b0, 0, 1'b1, "illegal9_nop");
        do_reset("pre_wrap");
`endif
        for (int i = 0; i < 5; i++) run(4'd0, 1'b0, 0, 1'b0, "wrap_nop");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
